// File: rtl/slice_scan_scheduler.sv
// slice_scan_scheduler
// Sequences one rotational slice of a HUB75-style panel. For every scan index
// it selects the cube_frame column, then for each colour bit-plane it shifts
// NUM_ROWS pixel pairs, latches them and shows them for DISPLAY_BASE<<plane
// cycles (binary-coded modulation).
//
// Ports:
//   clk_in, rst_n_in    clock, asynchronous active-low reset
//   dtheta_in/_valid_in new slice angle and its one-cycle strobe
//   dtheta_out          latched angle for the cube_frame lookup
//   col_idx_out         scan index for cube_frame column_index1/2
//   columns_in          cube_frame columns: low half feeds rgb0, high half rgb1
//   pix_clk_out, latch_out, oe_n_out, addr_out, rgb0_out, rgb1_out  panel pins
//   busy_out            a slice is in progress
//   slice_done_out      one-cycle pulse after the last display of a slice
//   overrun_out         sticky: an angle arrived while busy
//
// Optional build macro ABORT_ON_NEW_SLICE_EN: a strobe while busy abandons the
// current slice and restarts with the new angle. Without it the new angle is
// parked as pending and starts right after the current slice completes.
module slice_scan_scheduler #(
  parameter int SCAN_RATE      = 32,
  parameter int NUM_ROWS       = 64,
  parameter int RGB_RES        = 9,
  parameter int ROTATIONAL_RES = 256,
  parameter int DISPLAY_BASE   = 16,
  localparam int SW = $clog2(SCAN_RATE),
  localparam int TW = $clog2(ROTATIONAL_RES)
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [TW-1:0]                   dtheta_in,
  input  logic                            dtheta_valid_in,
  output logic [TW-1:0]                   dtheta_out,
  output logic [SW-1:0]                   col_idx_out,
  input  logic [2*NUM_ROWS*RGB_RES-1:0]   columns_in,
  output logic                            pix_clk_out,
  output logic                            latch_out,
  output logic                            oe_n_out,
  output logic [SW-1:0]                   addr_out,
  output logic [2:0]                      rgb0_out,
  output logic [2:0]                      rgb1_out,
  output logic                            busy_out,
  output logic                            slice_done_out,
  output logic                            overrun_out
);

  localparam int C  = RGB_RES / 3;
  localparam int BW = (C > 1) ? $clog2(C) : 1;
  localparam int PW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int DW = $clog2((DISPLAY_BASE << (C - 1)) + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREP    = 3'd1,
    SHIFT   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_t;

  state_t          state_r;
  logic [SW-1:0]   s_r;
  logic [BW-1:0]   b_r;
  logic [PW-1:0]   p_r;
  logic            phase_r;
  logic [DW-1:0]   disp_cnt_r;
  logic            pend_r;
  logic [TW-1:0]   pend_theta_r;

  logic [RGB_RES-1:0] pix0_s [NUM_ROWS];
  logic [RGB_RES-1:0] pix1_s [NUM_ROWS];
  logic [PW-1:0]      p_next_s;
  logic [DW-1:0]      disp_last_s;
  logic               last_pix_s;
  logic               last_plane_s;
  logic               last_scan_s;
  logic               slice_end_s;
  logic               abort_s;
  logic               park_s;

  // {R[pl], G[pl], B[pl]} of one pixel word
  function automatic logic [2:0] plane_rgb(input logic [RGB_RES-1:0] px,
                                           input logic [BW-1:0] pl);
    logic [RGB_RES-1:0] sh;
    sh = px >> pl;
    return {sh[2*C], sh[C], sh[0]};
  endfunction

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_pix
    assign pix0_s[g] = columns_in[g*RGB_RES +: RGB_RES];
    assign pix1_s[g] = columns_in[(NUM_ROWS + g)*RGB_RES +: RGB_RES];
  end

  assign p_next_s     = p_r + PW'(1);
  assign disp_last_s  = DW'((DISPLAY_BASE << b_r) - 1);
  assign last_pix_s   = (p_r == PW'(NUM_ROWS - 1));
  assign last_plane_s = (b_r == BW'(C - 1));
  assign last_scan_s  = (s_r == SW'(SCAN_RATE - 1));
  // Last display cycle of the whole slice: a strobe here simply becomes the next slice.
  assign slice_end_s  = (state_r == DISPLAY) && (disp_cnt_r == disp_last_s) &&
                        last_plane_s && last_scan_s;

`ifdef ABORT_ON_NEW_SLICE_EN
  assign abort_s = dtheta_valid_in && (state_r != IDLE);
  assign park_s  = 1'b0;
`else
  assign abort_s = 1'b0;
  assign park_s  = dtheta_valid_in && (state_r != IDLE) && !slice_end_s;
`endif

  // Slice sequencer: all panel and lookup outputs are registered here.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r        <= IDLE;
      s_r            <= '0;
      b_r            <= '0;
      p_r            <= '0;
      phase_r        <= 1'b0;
      disp_cnt_r     <= '0;
      pend_r         <= 1'b0;
      pend_theta_r   <= '0;
      dtheta_out     <= '0;
      col_idx_out    <= '0;
      pix_clk_out    <= 1'b0;
      latch_out      <= 1'b0;
      oe_n_out       <= 1'b1;
      addr_out       <= '0;
      rgb0_out       <= 3'b000;
      rgb1_out       <= 3'b000;
      busy_out       <= 1'b0;
      slice_done_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      slice_done_out <= 1'b0;
      latch_out      <= 1'b0;
      if (park_s) begin
        pend_r       <= 1'b1;
        pend_theta_r <= dtheta_in;
        overrun_out  <= 1'b1;
      end
      if (abort_s) begin
        overrun_out <= 1'b1;
        dtheta_out  <= dtheta_in;
        s_r         <= '0;
        b_r         <= '0;
        col_idx_out <= '0;
        oe_n_out    <= 1'b1;
        pix_clk_out <= 1'b0;
        state_r     <= PREP;
      end else begin
        case (state_r)
          IDLE: begin
            if (dtheta_valid_in) begin
              dtheta_out  <= dtheta_in;
              s_r         <= '0;
              b_r         <= '0;
              col_idx_out <= '0;
              busy_out    <= 1'b1;
              state_r     <= PREP;
            end else begin
              state_r <= IDLE;
            end
          end
          PREP: begin
            // columns_in has had a full cycle to follow col_idx_out
            p_r         <= '0;
            phase_r     <= 1'b0;
            pix_clk_out <= 1'b0;
            rgb0_out    <= plane_rgb(pix0_s[0], b_r);
            rgb1_out    <= plane_rgb(pix1_s[0], b_r);
            state_r     <= SHIFT;
          end
          SHIFT: begin
            if (!phase_r) begin
              phase_r     <= 1'b1;
              pix_clk_out <= 1'b1;
            end else if (last_pix_s) begin
              phase_r     <= 1'b0;
              pix_clk_out <= 1'b0;
              latch_out   <= 1'b1;
              addr_out    <= s_r;
              state_r     <= LATCH;
            end else begin
              phase_r     <= 1'b0;
              p_r         <= p_next_s;
              pix_clk_out <= 1'b0;
              rgb0_out    <= plane_rgb(pix0_s[p_next_s], b_r);
              rgb1_out    <= plane_rgb(pix1_s[p_next_s], b_r);
            end
          end
          LATCH: begin
            oe_n_out   <= 1'b0;
            disp_cnt_r <= '0;
            state_r    <= DISPLAY;
          end
          DISPLAY: begin
            if (disp_cnt_r != disp_last_s) begin
              disp_cnt_r <= disp_cnt_r + DW'(1);
            end else begin
              oe_n_out <= 1'b1;
              if (!last_plane_s) begin
                b_r     <= b_r + BW'(1);
                state_r <= PREP;
              end else if (!last_scan_s) begin
                s_r         <= s_r + SW'(1);
                col_idx_out <= s_r + SW'(1);
                b_r         <= '0;
                state_r     <= PREP;
              end else begin
                slice_done_out <= 1'b1;
                s_r            <= '0;
                b_r            <= '0;
                col_idx_out    <= '0;
                pend_r         <= 1'b0;
                // a same-cycle strobe is newer than any parked angle
                if (dtheta_valid_in) begin
                  dtheta_out <= dtheta_in;
                  state_r    <= PREP;
                end else if (pend_r) begin
                  dtheta_out <= pend_theta_r;
                  state_r    <= PREP;
                end else begin
                  busy_out <= 1'b0;
                  state_r  <= IDLE;
                end
              end
            end
          end
          default: begin
            state_r     <= IDLE;
            oe_n_out    <= 1'b1;
            pix_clk_out <= 1'b0;
            busy_out    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/slice_scan_scheduler.md
Name: slice_scan_scheduler

Overview:
- Sequences the cube_frame column lookup and drives a HUB75-style LED panel for one rotational slice at a time.
- On each new discretized angle from the rotation tracker, the block latches dtheta and walks every scan index.
- For each scan index it shifts NUM_ROWS pixel pairs out once per colour bit-plane, then latches and displays them with binary-coded-modulation timing.
- It sits between the angle tracker, the cube_frame lookup (combinational) and the panel pins.

Parameters:
- SCAN_RATE, 32: scan indices per slice; index width SW=$clog2(SCAN_RATE).
- NUM_ROWS, 64: pixels shifted per scan index per half.
- RGB_RES, 9: bits per pixel. Per-channel depth C=RGB_RES/3. R=[RGB_RES-1 -: C], G=[2C-1 -: C], B=[C-1:0].
- ROTATIONAL_RES, 256: angle resolution; TW=$clog2(ROTATIONAL_RES).
- DISPLAY_BASE, 16: display cycles for bit-plane 0; plane b displays DISPLAY_BASE<<b cycles.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: asynchronous, active-low reset.
- dtheta_in, input, TW: new slice angle.
- dtheta_valid_in, input, 1: single-cycle strobe; dtheta_in is valid this cycle.
- dtheta_out, output, TW: latched angle, drives cube_frame dtheta.
- col_idx_out, output, SW: current scan index; wired to both cube_frame column_index1 and column_index2.
- columns_in, input, 2*NUM_ROWS*RGB_RES: cube_frame columns; [0] feeds rgb0, [1] feeds rgb1.
- pix_clk_out, output, 1: panel shift clock.
- latch_out, output, 1: panel latch.
- oe_n_out, output, 1: panel output enable, active low.
- addr_out, output, SW: panel row address.
- rgb0_out, output, 3: {R,G,B} bit of current plane, half 0.
- rgb1_out, output, 3: {R,G,B} bit of current plane, half 1.
- busy_out, output, 1: slice in progress.
- slice_done_out, output, 1: one-cycle pulse after the last DISPLAY of a slice.
- overrun_out, output, 1: sticky; a strobe arrived while busy. Cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - oe_n_out=1.
  - pix_clk_out, latch_out, busy_out, slice_done_out, overrun_out = 0.
  - rgb0/1_out=0, addr_out=0, col_idx_out=0, dtheta_out=0.
  - Pending flag cleared.
  - Reset mid-slice abandons the slice with no further pulses.
- States: IDLE, PREP, SHIFT, LATCH, DISPLAY.
  - Counters: scan s (0..SCAN_RATE-1), plane b (0..C-1), pixel p (0..NUM_ROWS-1), phase bit, display counter.
- IDLE:
  - On dtheta_valid_in: dtheta_out<=dtheta_in, s=0, b=0, busy_out<=1, go to PREP.
- PREP (1 cycle):
  - col_idx_out=s, oe_n_out=1.
  - Allows columns_in to settle. Go to SHIFT with p=0, phase 0.
- SHIFT (2*NUM_ROWS cycles):
  - Phase 0: pix_clk_out<=0; rgb0_out<={R[b],G[b],B[b]} of columns_in[0][p]; rgb1_out likewise from columns_in[1][p].
  - Phase 1: pix_clk_out<=1, data held.
  - After phase 1 of p=NUM_ROWS-1, go to LATCH.
- LATCH (1 cycle):
  - latch_out=1, addr_out<=s, pix_clk_out=0, oe_n_out=1.
- DISPLAY (DISPLAY_BASE<<b cycles):
  - oe_n_out=0, all else held. Then oe_n_out=1.
  - If b<C-1: b++, go to PREP.
  - Else if s<SCAN_RATE-1: s++, b=0, go to PREP.
  - Else: slice_done_out pulses 1 cycle; then either restart with the pending angle (go to PREP, s=b=0) or go to IDLE with busy_out=0.
- Strobe while busy (not IDLE):
  - Angle stored as pending; latest strobe wins.
  - overrun_out<=1.
- Strobe in the same cycle as slice completion:
  - Treated as pending, so the new slice starts immediately.
  - overrun_out is not set.
- Cycles per plane = 2*NUM_ROWS + 2 + (DISPLAY_BASE<<b).
  - Defaults: planes take 146, 162 and 194 cycles.
  - Slice = 32 × 502 = 16064 cycles.

Optional Feature:
- Macro: ABORT_ON_NEW_SLICE_EN.
- Defined: a strobe while busy aborts the current slice at the next cycle.
  - oe_n_out<=1, pix_clk_out<=0.
  - No slice_done_out pulse.
  - New angle is latched; restart at PREP with s=b=0.
  - overrun_out is still set.
- Undefined: pending/finish-then-restart behaviour as above.

Test Plan:
- Reset:
  - Stimulus: assert rst_n_in=0 mid-SHIFT.
  - Required: outputs go to reset values in the same cycle with no clock edge needed; oe_n_out=1; no further pix_clk_out edges.
- Single slice, defaults:
  - Stimulus: strobe dtheta_in=0x2A.
  - Required: dtheta_out=0x2A next cycle; exactly 32×3×64=6144 pix_clk_out rising edges; 96 latch pulses; slice_done_out exactly 16064 cycles after PREP entry; then busy_out=0.
- Bit-plane data:
  - Stimulus: columns_in[0][5]=9'b101_010_110, s=0.
  - Required: at pixel 5, rgb0_out = 3'b100 (plane 0), 3'b011 (plane 1), 3'b101 (plane 2).
- Display timing:
  - Stimulus: observe oe_n_out=0 windows within one scan index.
  - Required: window lengths 16, 32, 64 cycles; addr_out equals s during each window.
- Overrun, feature undefined:
  - Stimulus: strobes at cycles 100 and 200 of a slice with 0x10 then 0x11.
  - Required: overrun_out=1; the slice completes; the next slice uses 0x11 with no IDLE gap.
- Abort, feature defined:
  - Stimulus: strobe 0x33 mid-DISPLAY.
  - Required: oe_n_out=1 next cycle; no slice_done_out; PREP restarts with col_idx_out=0 and dtheta_out=0x33.
